key_event_queue: RTL and testbench

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

---
 rtl/calc_input_pkg.sv | 31 +++
 rtl/event_fifo.sv | 54 +++++
 rtl/key_event_queue.sv | 133 +++++++++++++
 tb/tb_key_event_queue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_input_pkg.sv
// Shared types and helpers for the key event queue.
//   key_event_t  : one queued event, the key index and whether it is an auto-repeat.
//   rpt_state_t  : states of the auto-repeat timer.
//   ms_to_ticks  : converts a millisecond interval to clock cycles at a given frequency.
package calc_input_pkg;

    // Wide enough for any practical number of key lines. The top level uses
    // only the low bits it needs.
    localparam int KEY_CODE_W = 8;

    typedef struct packed {
        logic [KEY_CODE_W-1:0] keyCode;
        logic                  isRepeat;
    } key_event_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    // A zero result would make the timer limit underflow, so at least one
    // cycle is returned.
    function automatic int unsigned ms_to_ticks(input int unsigned freq_hz,
                                                 input int unsigned ms);
        int unsigned t;
        t = (freq_hz / 1000) * ms;
        return (t == 0) ? 1 : t;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with a valid/ready pop side.
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   push, push_data   : write request and data; ignored when full unless a pop
//                       happens in the same cycle
//   full              : all DEPTH entries occupied
//   pop_valid         : the head entry holds data
//   pop_ready         : consumer takes the head when pop_valid && pop_ready
//   pop_data          : head entry (undefined when pop_valid is low)
module event_fifo #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data
);

    localparam int AW = $clog2(DEPTH);

    // The extra MSB on each pointer separates "full" from "empty" when the
    // index bits are equal; DEPTH being a power of two makes wrap free.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              pop;
    logic              wr_en;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_valid = (wr_ptr != rd_ptr);
    assign pop       = pop_valid && pop_ready;
    // When full, a same-cycle pop frees the slot being written.
    assign wr_en     = push && (!full || pop);
    assign pop_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)   rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced active-low key lines into a queue of key events with
// auto-repeat for the most recently pressed key.
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   debounced   : key levels, 0 = pressed, already synchronous to clock
//   eventValid  : queue head holds an event
//   eventReady  : consumer takes the head when eventValid && eventReady
//   keyCode     : key index of the head event (0 when the queue is empty)
//   isRepeat    : head event is an auto-repeat (0 when the queue is empty)
//   dropped     : one-cycle pulse when an event is lost to a full queue
module key_event_queue
    import calc_input_pkg::*;
#(
    parameter int          width       = 5,
    parameter int unsigned freq        = 50000000,
    parameter int unsigned repeatDelay = 500,
    parameter int unsigned repeatRate  = 100,
    parameter int          depth       = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [width-1:0]         debounced,
    output logic                     eventValid,
    input  logic                     eventReady,
    output logic [$clog2(width)-1:0] keyCode,
    output logic                     isRepeat,
    output logic                     dropped
);

    localparam int          KW          = $clog2(width);
    localparam int unsigned DELAY_TICKS = ms_to_ticks(freq, repeatDelay);
    localparam int unsigned RATE_TICKS  = ms_to_ticks(freq, repeatRate);
    localparam int unsigned MAX_TICKS   = (DELAY_TICKS > RATE_TICKS) ? DELAY_TICKS : RATE_TICKS;
    localparam int          CNT_W       = $clog2(MAX_TICKS + 1);

    logic [width-1:0] prev;
    logic [width-1:0] press;
    logic             press_any;
    logic [KW-1:0]    press_idx;
    rpt_state_t       state;
    logic [KW-1:0]    activeKey;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] tick_limit;
    logic             key_held;
    logic             repeat_evt;
    logic             push;
    key_event_t       push_ev;
    key_event_t       head;
    logic [$bits(key_event_t)-1:0] head_bits;
    logic             fifo_full;
    logic             unused_head_code;

    // Falling-edge detect; only the lowest-index new press becomes an event.
    always_comb begin
        press     = prev & ~debounced;
        press_any = |press;
        press_idx = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (press[i]) press_idx = KW'(i);
        end
    end

    always_comb begin
        tick_limit = (state == RPT_DELAY) ? CNT_W'(DELAY_TICKS - 1) : CNT_W'(RATE_TICKS - 1);
        key_held   = ~debounced[activeKey];
        // A fresh press wins over a repeat due in the same cycle, and a key
        // seen released this cycle never produces a repeat.
        repeat_evt = !press_any && (state != RPT_IDLE) && key_held && (tick_cnt == tick_limit);
        push       = press_any || repeat_evt;
        push_ev.keyCode  = press_any ? KEY_CODE_W'(press_idx) : KEY_CODE_W'(activeKey);
        push_ev.isRepeat = !press_any;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev      <= '1;
            state     <= RPT_IDLE;
            activeKey <= '0;
            tick_cnt  <= '0;
            dropped   <= 1'b0;
        end else begin
            prev    <= debounced;
            dropped <= push && fifo_full && !(eventValid && eventReady);
            if (press_any) begin
                activeKey <= press_idx;
                state     <= RPT_DELAY;
                tick_cnt  <= '0;
            end else begin
                case (state)
                    RPT_DELAY, RPT_REPEAT: begin
                        if (!key_held) begin
                            state    <= RPT_IDLE;
                            tick_cnt <= '0;
                        end else if (tick_cnt == tick_limit) begin
                            state    <= RPT_REPEAT;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= RPT_IDLE;
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

    event_fifo #(
        .DATA_W ($bits(key_event_t)),
        .DEPTH  (depth)
    ) u_event_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_ev),
        .full      (fifo_full),
        .pop_valid (eventValid),
        .pop_ready (eventReady),
        .pop_data  (head_bits)
    );

    assign head = key_event_t'(head_bits);

    // Storage is not reset, so the head is masked while the queue is empty.
    assign keyCode  = eventValid ? head.keyCode[KW-1:0] : '0;
    assign isRepeat = eventValid & head.isRepeat;

    // Upper key-code bits are always zero for this width.
    assign unused_head_code = ^head.keyCode[KEY_CODE_W-1:KW];

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue with short timer settings
// (50-cycle first repeat, 20-cycle repeat period, 4-entry queue, 5 keys).
module tb_key_event_queue;

    localparam int W  = 5;
    localparam int KW = $clog2(W);

    typedef struct {
        int code;
        int rep;
        int cyc;   // cycle the event must be popped, -1 = any
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  debounced = '1;
    logic          eventReady = 1'b0;
    logic          eventValid;
    logic [KW-1:0] keyCode;
    logic          isRepeat;
    logic          dropped;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   drop_cnt = 0;

    key_event_queue #(
        .width       (5),
        .freq        (10000),
        .repeatDelay (5),
        .repeatRate  (2),
        .depth       (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .debounced  (debounced),
        .eventValid (eventValid),
        .eventReady (eventReady),
        .keyCode    (keyCode),
        .isRepeat   (isRepeat),
        .dropped    (dropped)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // One clock cycle: sample at the falling edge (scoreboard pop and drop
    // counting), then return 1 time unit after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (dropped === 1'b1) drop_cnt++;
        if (reset && eventValid === 1'b1 && eventReady) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pop_unexpected: got key=%0d rep=%0d at cycle %0d, required no event",
                         keyCode, isRepeat, cyc);
            end else begin
                e = sbq.pop_front();
                n_cmp++;
                if (keyCode !== KW'(e.code) || isRepeat !== 1'(e.rep)) begin
                    n_fail++;
                    $display("FAIL pop_event: got key=%0d rep=%0d, required key=%0d rep=%0d",
                             keyCode, isRepeat, e.code, e.rep);
                end
                if (e.cyc >= 0) begin
                    n_cmp++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL pop_cycle: key=%0d rep=%0d popped at cycle %0d, required %0d",
                                 e.code, e.rep, cyc, e.cyc);
                    end
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input int code, input int rep, input int at);
        exp_t e;
        e.code = code;
        e.rep  = rep;
        e.cyc  = at;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++;
        if (eventValid !== 1'b0 || keyCode !== '0 || isRepeat !== 1'b0 || dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b key=%0d rep=%b drop=%b, required 0 0 0 0",
                     eventValid, keyCode, isRepeat, dropped);
        end
        reset = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (eventValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got valid=%b, required 0", eventValid);
        end
    endtask

    task automatic test_single_tap();
        int c;
        eventReady   = 1'b1;
        debounced[2] = 1'b0;
        c = cyc;
        push_exp(2, 0, c + 1);
        tick();
        n_cmp++;
        if (eventValid !== 1'b1 || keyCode !== KW'(2)) begin
            n_fail++;
            $display("FAIL tap_latency: got valid=%b key=%0d one cycle after edge, required 1 2",
                     eventValid, keyCode);
        end
        repeat (9) tick();
        debounced[2] = 1'b1;
        repeat (70) tick();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL tap_drain: got %0d events still expected, required 0", sbq.size());
        end
    endtask

    task automatic test_hold();
        int c;
        eventReady   = 1'b1;
        debounced[1] = 1'b0;
        c = cyc;
        push_exp(1, 0, c + 1);
        push_exp(1, 1, c + 51);
        push_exp(1, 1, c + 71);
        push_exp(1, 1, c + 91);
        push_exp(1, 1, c + 111);
        repeat (120) tick();
        debounced[1] = 1'b1;
        repeat (60) tick();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL hold_drain: got %0d events still expected, required 0", sbq.size());
        end
    endtask

    task automatic test_simultaneous();
        int c;
        eventReady   = 1'b1;
        debounced[3] = 1'b0;
        debounced[0] = 1'b0;
        c = cyc;
        push_exp(0, 0, c + 1);
        repeat (5) tick();
        debounced = '1;
        repeat (10) tick();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL simul_drain: got %0d events still expected, required 0", sbq.size());
        end
    endtask

    task automatic test_overflow();
        int keys [6] = '{0, 1, 2, 3, 4, 0};
        int d0;
        eventReady = 1'b0;
        d0 = drop_cnt;
        for (int i = 0; i < 6; i++) begin
            debounced[keys[i]] = 1'b0;
            repeat (2) tick();
            debounced[keys[i]] = 1'b1;
            repeat (2) tick();
            if (i < 4) push_exp(keys[i], 0, -1);
            n_cmp++;
            if (eventValid !== 1'b1 || keyCode !== KW'(0) || isRepeat !== 1'b0) begin
                n_fail++;
                $display("FAIL overflow_head: after tap %0d got valid=%b key=%0d rep=%b, required 1 0 0",
                         i, eventValid, keyCode, isRepeat);
            end
        end
        n_cmp++;
        if (drop_cnt - d0 != 2) begin
            n_fail++;
            $display("FAIL overflow_drops: got %0d dropped cycles, required 2", drop_cnt - d0);
        end
        eventReady = 1'b1;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
        tick();
        n_cmp++;
        if (sbq.size() != 0 || eventValid !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_drain: got %0d left, valid=%b, required 0 left, valid=0",
                     sbq.size(), eventValid);
        end
    endtask

    task automatic test_full_with_pop();
        int keys [4] = '{1, 2, 3, 4};
        int d0;
        eventReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            debounced[keys[i]] = 1'b0;
            repeat (2) tick();
            debounced[keys[i]] = 1'b1;
            repeat (2) tick();
            push_exp(keys[i], 0, -1);
        end
        d0 = drop_cnt;
        // Press key 0 and pop the head in the same cycle.
        debounced[0] = 1'b0;
        eventReady   = 1'b1;
        tick();
        eventReady = 1'b0;
        push_exp(0, 0, -1);
        tick();
        debounced[0] = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (drop_cnt != d0) begin
            n_fail++;
            $display("FAIL fullpop_nodrop: got %0d dropped cycles, required 0", drop_cnt - d0);
        end
        // Queue must still hold four entries, so one more tap is lost.
        debounced[3] = 1'b0;
        repeat (2) tick();
        debounced[3] = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (drop_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL fullpop_occupancy: got %0d dropped cycles after extra tap, required 1",
                     drop_cnt - d0);
        end
        eventReady = 1'b1;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL fullpop_drain: got %0d events still expected, required 0", sbq.size());
        end
    endtask

    task automatic test_reset_mid_repeat();
        int r;
        eventReady   = 1'b0;
        debounced[3] = 1'b0;
        repeat (60) tick();
        n_cmp++;
        if (eventValid !== 1'b1 || keyCode !== KW'(3)) begin
            n_fail++;
            $display("FAIL midrep_queued: got valid=%b key=%0d, required 1 3", eventValid, keyCode);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (eventValid !== 1'b0 || keyCode !== '0 || isRepeat !== 1'b0) begin
            n_fail++;
            $display("FAIL midrep_reset_now: got valid=%b key=%0d rep=%b, required 0 0 0",
                     eventValid, keyCode, isRepeat);
        end
        repeat (3) tick();
        reset      = 1'b1;
        eventReady = 1'b1;
        r = cyc;
        push_exp(3, 0, r + 1);
        repeat (10) tick();
        debounced[3] = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL midrep_fresh_press: got %0d events still expected, required 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_tap();
        test_hold();
        test_simultaneous();
        test_overflow();
        test_full_with_pop();
        test_reset_mid_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
